// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
// Bus bundle between the single-cycle CPU data-memory port, the output
// stream consumer and data_mem_responder.
//   addr_dm   [10:0] CPU data-memory word address
//   acc       [15:0] CPU write data (accumulator)
//   rd, wr           CPU read / write strobes
//   dm_out    [15:0] read data back to the CPU (combinational)
//   out_data  [15:0] head word of the output FIFO
//   out_valid        FIFO non-empty, out_data valid
//   out_ready        consumer accepts out_data
// master: CPU + consumer side.  slave: data_mem_responder.
// ---------------------------------------------------------------------------
interface data_mem_responder_if;
    logic [10:0] addr_dm;
    logic [15:0] acc;
    logic        rd;
    logic        wr;
    logic [15:0] dm_out;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output addr_dm, acc, rd, wr, out_ready,
        input  dm_out, out_data, out_valid
    );

    modport slave (
        input  addr_dm, acc, rd, wr, out_ready,
        output dm_out, out_data, out_valid
    );
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Zero-wait-state data memory for a single-cycle CPU. Maps a word RAM, an
// output FIFO push port, a status register and a free-running 32-bit cycle
// counter into the 11-bit data address space:
//   0x000..RAM_WORDS-1  RAM (not reset)
//   0x7F0  FIFO_DATA    write pushes acc, reads return 0
//   0x7F1  STATUS       {10'b0, overflow, count[2:0], empty, full}; write clears overflow
//   0x7F2  CYCLE_LO     counter[15:0]; reading latches counter[31:16] into hi_shadow
//   0x7F3  CYCLE_HI     hi_shadow
// Ports:
//   gclk   system clock, rising edge
//   grst   asynchronous active-high reset
//   bus    data_mem_responder_if.slave (CPU port + output stream)
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4      // power of two, 1..8
) (
    input  logic                 gclk,
    input  logic                 grst,
    data_mem_responder_if.slave  bus
);

    localparam logic [10:0] A_FIFO = 11'h7F0;
    localparam logic [10:0] A_STAT = 11'h7F1;
    localparam logic [10:0] A_CLO  = 11'h7F2;
    localparam logic [10:0] A_CHI  = 11'h7F3;

    localparam int RAW = (RAM_WORDS  > 1) ? $clog2(RAM_WORDS)  : 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // count needs to hold FIFO_DEPTH itself (up to 8)
    localparam logic [3:0] DEPTH = 4'(FIFO_DEPTH);

    // ---------------------------------------------------------------- state
    logic [15:0]   ram      [RAM_WORDS];
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    count, count_nxt;
    logic          out_valid_q;
    logic          overflow;
    logic [31:0]   cyc;
    logic [15:0]   hi_shadow;

    // --------------------------------------------------------------- decode
    logic          is_ram;
    logic [RAW-1:0] ram_idx;
    logic          full, empty;
    logic          push, pop, push_drop;
    logic [15:0]   status;

    assign is_ram  = 32'(bus.addr_dm) < 32'(RAM_WORDS);
    assign ram_idx = bus.addr_dm[RAW-1:0];

    assign full  = (count == DEPTH);
    assign empty = (count == 4'd0);

    // Pop is driven only by the registered valid, so a word pushed this
    // cycle can never leave in the same cycle.
    assign pop       = out_valid_q && bus.out_ready;
    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign push      = bus.wr && (bus.addr_dm == A_FIFO) && (!full || pop);
    assign push_drop = bus.wr && (bus.addr_dm == A_FIFO) && full && !pop;

    // count[2:0] wraps for depth 8 (8 shows as 0 with FULL set)
    assign status = {10'd0, overflow, count[2:0], empty, full};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 4'd1;
            2'b01:   count_nxt = count - 4'd1;
            default: count_nxt = count;
        endcase
    end

    // ----------------------------------------------------------------- FIFO
    // Storage is reset too so out_data reads 0 out of reset and after a
    // mid-operation reset discards the queue.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.acc;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count       <= count_nxt;
            out_valid_q <= (count_nxt != 4'd0);
            // a dropped push outranks a same-cycle clear
            if (push_drop)
                overflow <= 1'b1;
            else if (bus.wr && (bus.addr_dm == A_STAT))
                overflow <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = fifo_mem[rd_ptr];

    // ------------------------------------------------------- cycle counter
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            cyc       <= '0;
            hi_shadow <= '0;
        end else begin
            cyc <= cyc + 32'd1;
            // latch the upper half together with the LO read so LO-then-HI
            // forms one coherent 32-bit snapshot
            if (bus.rd && (bus.addr_dm == A_CLO))
                hi_shadow <= cyc[31:16];
        end
    end

    // ------------------------------------------------------------------ RAM
    always_ff @(posedge gclk) begin
        if (bus.wr && is_ram)
            ram[ram_idx] <= bus.acc;
    end

    // ------------------------------------------------------------ read mux
    // Purely combinational from current state, so a same-cycle write is
    // seen only after the edge.
    always_comb begin
        bus.dm_out = '0;
        if (bus.rd) begin
            if (is_ram) begin
                bus.dm_out = ram[ram_idx];
            end else begin
                case (bus.addr_dm)
                    A_STAT:  bus.dm_out = status;
                    A_CLO:   bus.dm_out = cyc[15:0];
                    A_CHI:   bus.dm_out = hi_shadow;
                    default: bus.dm_out = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (RAM_WORDS=1024, FIFO_DEPTH=4).
module tb_data_mem_responder;

    localparam logic [10:0] A_FIFO = 11'h7F0;
    localparam logic [10:0] A_STAT = 11'h7F1;
    localparam logic [10:0] A_CLO  = 11'h7F2;
    localparam logic [10:0] A_CHI  = 11'h7F3;

    logic        gclk;
    logic        grst;
    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc_ref     = 0;   // edges seen since reset release

    data_mem_responder_if bus();

    data_mem_responder #(.RAM_WORDS(1024), .FIFO_DEPTH(4)) dut (
        .gclk (gclk),
        .grst (grst),
        .bus  (bus.slave)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge gclk);
        if (!grst) cyc_ref++;
        #2;
    endtask

    task automatic drive(input logic r, input logic w, input logic [10:0] a, input logic [15:0] d);
        bus.rd      = r;
        bus.wr      = w;
        bus.addr_dm = a;
        bus.acc     = d;
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [10:0] a, input logic [15:0] exp);
        drive(1'b1, 1'b0, a, 16'h0000);
        check(tag, bus.dm_out, exp);
    endtask

    task automatic vld_chk(input string tag, input logic exp);
        check(tag, {15'd0, bus.out_valid}, {15'd0, exp});
    endtask

    initial begin
        logic [15:0] drain_exp [4];
        drain_exp = '{16'h00A2, 16'h00A3, 16'h00A4, 16'h00C0};

        // ---------------- reset state
        grst          = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 1'b0, 11'h000, 16'h0000);
        #7;
        vld_chk("rst_valid", 1'b0);
        check("rst_data", bus.out_data, 16'h0000);
        rd_chk("rst_status", A_STAT, 16'h0002);
        rd_chk("rst_cyc_lo", A_CLO, 16'h0000);
        rd_chk("rst_cyc_hi", A_CHI, 16'h0000);

        // release between edges; counter reads 0 until the first edge
        grst    = 1'b0;
        cyc_ref = 0;
        rd_chk("cyc_first", A_CLO, 16'h0000);
        cyc();
        rd_chk("cyc_one", A_CLO, 16'h0001);
        cyc();
        rd_chk("cyc_two", A_CLO, 16'h0002);

        // ---------------- RAM
        drive(1'b0, 1'b1, 11'h005, 16'h1111);
        cyc();
        drive(1'b1, 1'b1, 11'h005, 16'h1234);
        check("ram_rd_before_wr", bus.dm_out, 16'h1111);
        cyc();
        rd_chk("ram_readback", 11'h005, 16'h1234);
        drive(1'b0, 1'b0, 11'h005, 16'h0000);
        check("rd_low_zero", bus.dm_out, 16'h0000);
        rd_chk("unmapped_400", 11'h400, 16'h0000);
        rd_chk("fifo_data_rd", A_FIFO, 16'h0000);
        drive(1'b0, 1'b1, 11'h3FF, 16'hBEEF);
        cyc();
        rd_chk("ram_top", 11'h3FF, 16'hBEEF);
        drive(1'b0, 1'b1, 11'h000, 16'h0F0F);
        cyc();
        drive(1'b0, 1'b1, 11'h400, 16'hDEAD);
        cyc();
        rd_chk("ram0_after_unmapped_wr", 11'h000, 16'h0F0F);

        // counter writes are ignored
        drive(1'b0, 1'b1, A_CLO, 16'h0000);
        cyc();
        drive(1'b0, 1'b1, A_CHI, 16'h0000);
        cyc();
        rd_chk("cyc_after_wr", A_CLO, 16'(cyc_ref));

        // ---------------- FIFO fill + overflow, consumer stalled
        drive(1'b0, 1'b1, A_FIFO, 16'h00A1);
        vld_chk("no_bypass_a1", 1'b0);
        cyc();
        vld_chk("valid_after_push", 1'b1);
        check("head_a1", bus.out_data, 16'h00A1);
        for (int i = 2; i <= 5; i++) begin
            drive(1'b0, 1'b1, A_FIFO, 16'(16'h00A0 + i));
            cyc();
        end
        rd_chk("status_full_ovf", A_STAT, 16'h0031);
        check("head_after_ovf", bus.out_data, 16'h00A1);
        drive(1'b1, 1'b1, A_STAT, 16'h0000);
        check("status_rd_during_wr", bus.dm_out, 16'h0031);
        cyc();
        rd_chk("status_ovf_clr", A_STAT, 16'h0011);

        // full FIFO: push with same-cycle pop is accepted
        bus.out_ready = 1'b1;
        drive(1'b0, 1'b1, A_FIFO, 16'h00C0);
        cyc();
        bus.out_ready = 1'b0;
        rd_chk("status_pushpop", A_STAT, 16'h0011);
        check("head_a2", bus.out_data, 16'h00A2);

        // drain in order
        bus.out_ready = 1'b1;
        drive(1'b0, 1'b0, 11'h000, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            check("drain_data", bus.out_data, drain_exp[i]);
            vld_chk("drain_valid", 1'b1);
            cyc();
        end
        vld_chk("drained_valid", 1'b0);
        rd_chk("status_empty", A_STAT, 16'h0002);

        // ---------------- streaming with consumer ready
        drive(1'b0, 1'b1, A_FIFO, 16'h00B0);
        vld_chk("no_bypass_b0", 1'b0);
        cyc();
        drive(1'b0, 1'b1, A_FIFO, 16'h00B1);
        vld_chk("b0_valid", 1'b1);
        check("b0_data", bus.out_data, 16'h00B0);
        cyc();
        drive(1'b0, 1'b0, 11'h000, 16'h0000);
        vld_chk("b1_valid", 1'b1);
        check("b1_data", bus.out_data, 16'h00B1);
        cyc();
        vld_chk("b_empty_valid", 1'b0);
        rd_chk("b_status_empty", A_STAT, 16'h0002);

        // ---------------- asynchronous reset with 3 words queued
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, A_FIFO, 16'(16'h00D0 + i));
            cyc();
        end
        rd_chk("status_three", A_STAT, 16'h000C);
        drive(1'b0, 1'b0, 11'h000, 16'h0000);
        grst = 1'b1;
        #1;
        vld_chk("async_rst_valid", 1'b0);
        check("async_rst_data", bus.out_data, 16'h0000);
        cyc();
        grst    = 1'b0;
        cyc_ref = 0;
        rd_chk("status_after_rst", A_STAT, 16'h0002);
        rd_chk("cyc_after_rst", A_CLO, 16'h0000);
        rd_chk("ram_kept", 11'h005, 16'h1234);
        drive(1'b0, 1'b0, 11'h000, 16'h0000);
        cyc();
        vld_chk("no_valid_after_rst", 1'b0);

        // ---------------- coherent LO/HI snapshot across a 16-bit carry
        while (cyc_ref < 32'd65535) cyc();
        rd_chk("snap_lo", A_CLO, 16'hFFFF);
        cyc();
        rd_chk("snap_hi", A_CHI, 16'h0000);
        rd_chk("lo_after_carry", A_CLO, 16'h0000);
        cyc();
        rd_chk("hi_after_carry", A_CHI, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
